load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
// - Sits between execute stage and the data register_file/BRAM (clka, wea[3:0], addra, dina, douta).
// - Turns byte/half/word load/store requests into per-lane write enables, word address, replicated write data.
// - Waits out the memory read latency; returns one aligned, sign/zero-extended load result per request.
// PARAMETERS
// - RD_LATENCY  1   cycles from addra presented to douta valid (1..3)
// - AW          32  request byte-address width
// PORTS
// - clka          in   1   clock; all state updates on rising edge
// - rst_n         in   1   asynchronous, active-low reset
// - req_valid     in   1   request present
// - req_ready     out  1   unit can accept; transfer = req_valid & req_ready
// - req_is_store  in   1   1 = store, 0 = load
// - req_size      in   2   00 byte, 01 half, 10 word (11 reserved = word)
// - req_signed    in   1   loads: 1 sign-extend, 0 zero-extend
// - req_addr      in   AW  byte address
// - req_wdata     in   32  store data, LSB-justified
// - mem_wea       out  4   byte-lane write enables to memory
// - mem_addra     out  32  word index = {2'b0, addr[31:2]}
// - mem_dina      out  32  lane-replicated store data
// - mem_douta     in   32  memory read data
// - rsp_valid     out  1   one-cycle completion pulse (loads and stores)
// - rsp_rdata     out  32  extended load data; 0 for stores
// - rsp_err       out  1   misaligned access (MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1, mem_wea=0, mem_addra=0, mem_dina=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
// - FSM IDLE -> ACCESS -> (load: WAIT) -> DONE -> IDLE/ACCESS. req_ready=1 in IDLE and DONE only.
// - Accept (cycle 0): latch is_store, size, signed, addr, wdata.
// - ACCESS (cycle 1): mem_addra driven; store: mem_wea = lane mask for exactly this one cycle; load: mem_wea=0.
// - WAIT: addra held for RD_LATENCY-1 further cycles (down-counter, skipped when RD_LATENCY=1).
// - DONE: rsp_valid=1 one cycle. Store rsp at cycle 2; load rsp at cycle 2+RD_LATENCY-1... i.e. RD_LATENCY+1.
//   Load captures mem_douta on the edge entering DONE; rsp_rdata held until next rsp_valid.
// - Accept in DONE goes straight to ACCESS: back-to-back throughput one op per 2 (store) / RD_LATENCY+1 (load) cycles.
// - Lane mask (little-endian): byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
// - mem_dina: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
// - Load extract: byte douta[8*addr[1:0]+:8], half douta[16*addr[1]+:16], word douta; extend per req_signed.
// - rsp_valid never asserts without a prior accepted request; no response backpressure (consumer must take pulse).
// - Async reset mid-operation: FSM to IDLE immediately, mem_wea drops same instant, in-flight op dropped, no rsp.
// - req_valid while req_ready=0: ignored, inputs not sampled.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no memory access (mem_wea stays 0),
//   DONE reached in cycle 1, rsp_valid=1 with rsp_err=1, rsp_rdata=0.
// - MISALIGN_TRAP_EN undefined: low address bits forced aligned (half clears addr[0], word clears addr[1:0]);
//   access proceeds normally; rsp_err constant 0.
// STRUCTURE
// - Package kgp_mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state enum lsu_state_t, lane-mask function.
// - One sub-module lsu_align: combinational lane mask, store replication, load extract + extension; shared by both paths.
// - Top holds FSM, latency counter, request latches, registered memory and response outputs.
// TESTING
// - Word store 0xDEADBEEF @0x10 -> cycle1 mem_addra=4, mem_wea=4'b1111, mem_dina=0xDEADBEEF; rsp_valid cycle2, rdata=0.
// - Byte store 0xA5 @0x13 -> mem_wea=4'b1000, mem_dina=0xA5A5A5A5; subsequent word load @0x10 -> 0xA5ADBEEF.
// - Signed byte load @0x13 (mem 0xA5ADBEEF) -> rsp_rdata=0xFFFFFFA5; unsigned -> 0x000000A5; RD_LATENCY=1 rsp at cycle 2.
// - RD_LATENCY=3, signed half load @0x12 of 0x8000xxxx -> addra held 3 cycles, rsp cycle 4, rdata=0xFFFF8000.
// - Half store @0x11: with MISALIGN_TRAP_EN -> wea never set, rsp_err=1 cycle 1; without -> wea=4'b0011 @word 4.
// - rst_n low during load WAIT -> outputs to reset values same instant, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/kgp_mem_pkg.sv
// Shared encodings for the load/store path: access sizes, LSU state type,
// and the little-endian byte-lane mask helper.
package kgp_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is reserved and treated as word

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } lsu_state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the store and load paths:
// write-lane mask, store-data replication, load extract and extension.
module lsu_align
  import kgp_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] douta,
  output logic [3:0]  wea_mask,
  output logic [31:0] dina,
  output logic [31:0] rdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign wea_mask = lane_mask(size, addr_lo);
  assign ld_byte  = douta[{addr_lo, 3'b000} +: 8];
  assign ld_half  = douta[{addr_lo[1], 4'b0000} +: 16];

  // Replicate store data across lanes and extend the selected load field.
  always_comb begin
    case (size)
      SZ_BYTE: begin
        dina  = {4{wdata[7:0]}};
        rdata = {{24{is_signed & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        dina  = {2{wdata[15:0]}};
        rdata = {{16{is_signed & ld_half[15]}}, ld_half};
      end
      default: begin
        dina  = wdata;
        rdata = douta;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a BRAM-style data memory.
// Optional feature: define MISALIGN_TRAP_EN to report misaligned accesses via
// rsp_err instead of silently aligning them.
module load_store_unit
  import kgp_mem_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned AW         = 32
) (
  input  logic          clka,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic [3:0]    mem_wea,
  output logic [31:0]   mem_addra,
  output logic [31:0]   mem_dina,
  input  logic [31:0]   mem_douta,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  lsu_state_t  state, state_d;
  logic [1:0]  cnt;
  logic        l_store, l_signed;
  logic [1:0]  l_size, l_lo;
  logic        accept, busy, trap, capture;
  logic [1:0]  req_lo;
  logic [1:0]  a_size, a_lo;
  logic        a_signed;
  logic [3:0]  al_mask;
  logic [31:0] al_dina, al_rdata;

  assign req_ready = (state == IDLE) || (state == DONE);
  assign accept    = req_valid & req_ready;
  assign busy      = ~req_ready;
  assign rsp_valid = (state == DONE);

  // Force the low address bits to the natural alignment of the access size.
  always_comb begin
    case (req_size)
      SZ_BYTE: req_lo = req_addr[1:0];
      SZ_HALF: req_lo = {req_addr[1], 1'b0};
      default: req_lo = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (req_size == SZ_BYTE) ? 1'b0 :
                      (req_size == SZ_HALF) ? req_addr[0] : (req_addr[1:0] != 2'b00);
  assign trap = accept & misaligned;
`else
  assign trap = 1'b0;
`endif

  // One aligner serves both paths: incoming request fields while accepting
  // (store mask/data), latched fields while an access is in flight (load extract).
  assign a_size   = busy ? l_size   : req_size;
  assign a_lo     = busy ? l_lo     : req_lo;
  assign a_signed = busy ? l_signed : req_signed;

  lsu_align u_align (
    .size      (a_size),
    .addr_lo   (a_lo),
    .is_signed (a_signed),
    .wdata     (req_wdata),
    .douta     (mem_douta),
    .wea_mask  (al_mask),
    .dina      (al_dina),
    .rdata     (al_rdata)
  );

  // Next-state logic; capture marks the edge on which load data is taken.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) state_d = trap ? DONE : ACCESS;
        else        state_d = IDLE;
      end
      ACCESS: begin
        if (l_store) begin
          state_d = DONE;
        end else if (RD_LATENCY <= 1) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Request latches, registered memory interface, latency counter, load result.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      l_store   <= 1'b0;
      l_signed  <= 1'b0;
      l_size    <= '0;
      l_lo      <= '0;
      mem_wea   <= '0;
      mem_addra <= '0;
      mem_dina  <= '0;
      rsp_rdata <= '0;
    end else begin
      mem_wea <= '0;
      if (accept && !trap) begin
        l_store   <= req_is_store;
        l_size    <= req_size;
        l_signed  <= req_signed;
        l_lo      <= req_lo;
        mem_addra <= 32'(req_addr[AW-1:2]);
        mem_dina  <= al_dina;
        if (req_is_store) mem_wea <= al_mask;
      end
      if (state == ACCESS)    cnt <= WAIT_INIT;
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (trap || (state == ACCESS && l_store)) rsp_rdata <= '0;
      else if (capture)                         rsp_rdata <= al_rdata;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Error flag follows each accepted request and is held with the response.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (accept) rsp_err <= trap;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
